commit_trace_arbiter: RTL and testbench

COMMIT_TRACE_ARBITER -- requirements
Module: commit_trace_arbiter

---
 rtl/commit_trace_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_commit_trace_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_arbiter.sv
// commit_trace_arbiter
// Merges the commit-trace streams of two harts into one harness commit port.
// Each hart feeds a DEPTH-entry FIFO; records offered while a FIFO is full are
// dropped and flagged in the sticky overflow bits. A single registered output
// stage takes the head of one FIFO per load, round-robin when both have data.
//
// Optional feature: define COMMIT_TRACE_ARB_SEQ_TAG_EN to tag every emitted
// record with a 64-bit sequence number (first record after reset is 0).
// Without it out_tag is tied to zero and no counter is built.
//
// Payload layout, MSB to LSB: debug_pc[39:0], debug_inst[31:0],
// debug_wdata[63:0], ldst[4:0], dst_rtype[2:0].
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module commit_trace_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  HART0_ID = 8'd0,
    parameter logic [7:0]  HART1_ID = 8'd1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         h0_valid,
    input  logic [143:0] h0_payload,
    output logic         h0_ready,
    input  logic         h1_valid,
    input  logic [143:0] h1_payload,
    output logic         h1_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_hartid,
    output logic [143:0] out_payload,
    output logic [63:0]  out_tag,
    output logic [1:0]   overflow
);

    localparam int unsigned PW = 144;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Per-hart FIFO storage and bookkeeping, index 0 = hart 0, 1 = hart 1
    logic [PW-1:0] r_mem   [2][DEPTH];
    logic [AW-1:0] r_wptr  [2];
    logic [AW-1:0] r_rptr  [2];
    logic [CW-1:0] r_count [2];

    logic [PW-1:0] w_in_payload [2];
    logic [PW-1:0] w_head       [2];
    logic [1:0]    w_in_valid;
    logic [1:0]    w_ready;
    logic [1:0]    w_nonempty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;

    // Arbitration and output stage
    logic          r_last_grant;   // 1 = hart 1 was granted most recently
    logic          w_load;
    logic          w_any;
    logic          w_grant;        // 1 = hart 1 wins this load
    logic          r_out_valid;
    logic [7:0]    r_out_hartid;
    logic [PW-1:0] r_out_payload;
    logic [1:0]    r_overflow;

    assign w_in_valid      = {h1_valid, h0_valid};
    assign w_in_payload[0] = h0_payload;
    assign w_in_payload[1] = h1_payload;

    // FIFO status: ready comes only from registered occupancy, so a pop in the
    // same cycle never opens a full FIFO.
    // NOTE: every always_comb output gets a default before any condition, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        w_ready    = '0;
        w_nonempty = '0;
        for (int n = 0; n < 2; n++) begin
            w_ready[n]    = (r_count[n] != CW'(DEPTH));
            w_nonempty[n] = (r_count[n] != '0);
            w_head[n]     = r_mem[n][r_rptr[n]];
        end
    end

    assign w_push = w_in_valid & w_ready;

    // Round-robin grant: on a tie the hart not served last wins, otherwise
    // whichever FIFO holds data.
    always_comb begin
        w_any   = |w_nonempty;
        w_grant = 1'b0;
        if (&w_nonempty) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = ~w_nonempty[0];
        end
    end

    assign w_load   = ~r_out_valid | out_ready;
    assign w_pop[0] = w_load & w_any & ~w_grant;
    assign w_pop[1] = w_load & w_any &  w_grant;

    // FIFO data array write port.
    // NOTE: the storage array has no reset; pointers and occupancy define what is valid, so stale contents are never observed.
    always_ff @(posedge clock) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) begin
                r_mem[n][r_wptr[n]] <= w_in_payload[n];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap modulo DEPTH by width.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                r_wptr[n]  <= '0;
                r_rptr[n]  <= '0;
                r_count[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) begin
                    r_wptr[n] <= r_wptr[n] + AW'(1);
                end
                if (w_pop[n]) begin
                    r_rptr[n] <= r_rptr[n] + AW'(1);
                end
                r_count[n] <= r_count[n] + CW'(w_push[n]) - CW'(w_pop[n]);
            end
        end
    end

    // Sticky drop flags: set when a hart offers a record its FIFO cannot take.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 2'b00;
        end else begin
            r_overflow <= r_overflow | (w_in_valid & ~w_ready);
        end
    end

    // Output register: reloads when empty or accepted; holds under backpressure.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_hartid  <= 8'd0;
            r_out_payload <= '0;
            r_last_grant  <= 1'b1;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid   <= 1'b1;
                r_out_hartid  <= w_grant ? HART1_ID : HART0_ID;
                r_out_payload <= w_head[w_grant];
                r_last_grant  <= w_grant;
            end else begin
                r_out_valid   <= 1'b0;
            end
        end
    end

`ifdef COMMIT_TRACE_ARB_SEQ_TAG_EN
    logic [63:0] r_seq;
    logic [63:0] r_out_tag;

    // Sequence tag: captured with each record that makes out_valid high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_seq     <= 64'd0;
            r_out_tag <= 64'd0;
        end else if (w_load && w_any) begin
            r_out_tag <= r_seq;
            r_seq     <= r_seq + 64'd1;
        end
    end

    assign out_tag = r_out_tag;
`else
    assign out_tag = 64'd0;
`endif

    assign h0_ready    = w_ready[0];
    assign h1_ready    = w_ready[1];
    assign out_valid   = r_out_valid;
    assign out_hartid  = r_out_hartid;
    assign out_payload = r_out_payload;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_commit_trace_arbiter.sv
// Self-checking bench for commit_trace_arbiter: directed scenarios plus a
// randomized run compared against a queue-based reference model.
// Honours COMMIT_TRACE_ARB_SEQ_TAG_EN for the expected out_tag values.

module tb_commit_trace_arbiter;

    localparam int          DEPTH = 4;
    localparam logic [7:0]  H0    = 8'hA0;
    localparam logic [7:0]  H1    = 8'h51;

    logic         clock;
    logic         reset;
    logic         h0_valid;
    logic [143:0] h0_payload;
    logic         h0_ready;
    logic         h1_valid;
    logic [143:0] h1_payload;
    logic         h1_ready;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_hartid;
    logic [143:0] out_payload;
    logic [63:0]  out_tag;
    logic [1:0]   overflow;

    int n_checks = 0;
    int n_pass   = 0;

    commit_trace_arbiter #(
        .DEPTH    (DEPTH),
        .HART0_ID (H0),
        .HART1_ID (H1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .h0_valid    (h0_valid),
        .h0_payload  (h0_payload),
        .h0_ready    (h0_ready),
        .h1_valid    (h1_valid),
        .h1_payload  (h1_payload),
        .h1_ready    (h1_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hartid  (out_hartid),
        .out_payload (out_payload),
        .out_tag     (out_tag),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // Each hart is a bounded queue; the output is one slot that refills from
    // the non-empty queue, alternating harts when both have data.
    logic [143:0] q0[$];
    logic [143:0] q1[$];
    logic         m_out_valid;
    logic [7:0]   m_hartid;
    logic [143:0] m_payload;
    logic [63:0]  m_tag;
    logic [63:0]  m_seq;
    logic         m_served1;     // hart 1 was served most recently
    logic [1:0]   m_ovf;

    always @(posedge clock or negedge reset) begin : model
        logic take1;
        logic acc0;
        logic acc1;
        if (!reset) begin
            q0.delete();
            q1.delete();
            m_out_valid <= 1'b0;
            m_hartid    <= 8'd0;
            m_payload   <= '0;
            m_tag       <= 64'd0;
            m_seq       <= 64'd0;
            m_served1   <= 1'b1;
            m_ovf       <= 2'b00;
        end else begin
            acc0 = (q0.size() < DEPTH);
            acc1 = (q1.size() < DEPTH);
            if (!m_out_valid || out_ready) begin
                if (q0.size() == 0 && q1.size() == 0) begin
                    m_out_valid <= 1'b0;
                end else begin
                    if (q0.size() == 0)      take1 = 1'b1;
                    else if (q1.size() == 0) take1 = 1'b0;
                    else                     take1 = !m_served1;
                    m_out_valid <= 1'b1;
                    m_hartid    <= take1 ? H1 : H0;
                    m_payload   <= take1 ? q1.pop_front() : q0.pop_front();
                    m_served1   <= take1;
`ifdef COMMIT_TRACE_ARB_SEQ_TAG_EN
                    m_tag       <= m_seq;
                    m_seq       <= m_seq + 64'd1;
`endif
                end
            end
            if (h0_valid) begin
                if (acc0) q0.push_back(h0_payload);
                else      m_ovf[0] <= 1'b1;
            end
            if (h1_valid) begin
                if (acc1) q1.push_back(h1_payload);
                else      m_ovf[1] <= 1'b1;
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    function automatic logic [143:0] make_rec(input logic [39:0] pc, input logic [31:0] k);
        return {pc, 32'h0000_0013 + k, 32'hC0DE_0000, k, k[4:0], k[2:0]};
    endfunction

    function automatic logic [143:0] rand_rec();
        return {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
    endfunction

    function automatic logic [63:0] exp_tag(input int k);
`ifdef COMMIT_TRACE_ARB_SEQ_TAG_EN
        return 64'(k);
`else
        return 64'd0 & 64'(k);
`endif
    endfunction

    task automatic idle_inputs();
        h0_valid   = 1'b0;
        h1_valid   = 1'b0;
        h0_payload = '0;
        h1_payload = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        out_ready = 1'b1;
        #3;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_hartid !== 8'd0) $display("FAIL reset_hartid got=%0h exp=0", out_hartid); else n_pass++;
        n_checks++; if (out_payload !== 144'd0) $display("FAIL reset_payload got=%0h exp=0", out_payload); else n_pass++;
        n_checks++; if (out_tag !== 64'd0) $display("FAIL reset_tag got=%0h exp=0", out_tag); else n_pass++;
        n_checks++; if (overflow !== 2'b00) $display("FAIL reset_overflow got=%b exp=00", overflow); else n_pass++;
        n_checks++; if ({h1_ready, h0_ready} !== 2'b11) $display("FAIL reset_ready got=%b exp=11", {h1_ready, h0_ready}); else n_pass++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_release_valid got=%0b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_single_hart();
        logic [143:0] rec;
        rec = make_rec(40'h80_0000_0000, 32'd7);
        out_ready  = 1'b1;
        h0_valid   = 1'b1;
        h0_payload = rec;
        @(negedge clock);
        h0_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_cycle1_valid got=%0b exp=0", out_valid); else n_pass++;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_cycle2_valid got=%0b exp=1", out_valid); else n_pass++;
        n_checks++; if (out_hartid !== H0) $display("FAIL single_hartid got=%0h exp=%0h", out_hartid, H0); else n_pass++;
        n_checks++; if (out_payload !== rec) $display("FAIL single_payload got=%0h exp=%0h", out_payload, rec); else n_pass++;
        n_checks++; if (out_tag !== 64'd0) $display("FAIL single_tag got=%0h exp=0", out_tag); else n_pass++;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain_valid got=%0b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_tie();
        logic [143:0] exp_rec [4];
        logic [7:0]   exp_id  [4];
        do_reset();
        exp_rec[0] = make_rec(40'h10_0000_0000, 32'd0);
        exp_rec[1] = make_rec(40'h20_0000_0000, 32'd1);
        exp_rec[2] = make_rec(40'h10_0000_0004, 32'd2);
        exp_rec[3] = make_rec(40'h20_0000_0004, 32'd3);
        exp_id[0] = H0; exp_id[1] = H1; exp_id[2] = H0; exp_id[3] = H1;
        out_ready  = 1'b1;
        h0_valid   = 1'b1; h0_payload = exp_rec[0];
        h1_valid   = 1'b1; h1_payload = exp_rec[1];
        @(negedge clock);
        h0_payload = exp_rec[2];
        h1_payload = exp_rec[3];
        @(negedge clock);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL tie_valid[%0d] got=%0b exp=1", i, out_valid); else n_pass++;
            n_checks++; if (out_hartid !== exp_id[i]) $display("FAIL tie_hartid[%0d] got=%0h exp=%0h", i, out_hartid, exp_id[i]); else n_pass++;
            n_checks++; if (out_payload !== exp_rec[i]) $display("FAIL tie_payload[%0d] got=%0h exp=%0h", i, out_payload, exp_rec[i]); else n_pass++;
            n_checks++; if (out_tag !== exp_tag(i)) $display("FAIL tie_tag[%0d] got=%0h exp=%0h", i, out_tag, exp_tag(i)); else n_pass++;
            @(negedge clock);
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL tie_end_valid got=%0b exp=0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [143:0] first;
        logic [143:0] b [5];
        logic [143:0] exp_rec [5];
        logic [7:0]   exp_id  [5];
        do_reset();
        out_ready = 1'b0;
        first = make_rec(40'h30_0000_0000, 32'd100);
        for (int i = 0; i < 5; i++) b[i] = make_rec(40'h40_0000_0000 + 40'(4 * i), 32'(200 + i));
        h0_valid = 1'b1; h0_payload = first;
        @(negedge clock);
        h0_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_loaded_valid got=%0b exp=1", out_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            h1_valid = 1'b1; h1_payload = b[i];
            n_checks++; if (h1_ready !== (i < 4)) $display("FAIL bp_h1_ready[%0d] got=%0b exp=%0b", i, h1_ready, (i < 4)); else n_pass++;
            @(negedge clock);
            n_checks++; if (out_payload !== first || out_valid !== 1'b1 || out_hartid !== H0) $display("FAIL bp_hold[%0d] got=%0h exp=%0h", i, out_payload, first); else n_pass++;
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            n_checks++; if (out_payload !== first || out_valid !== 1'b1) $display("FAIL bp_hold_idle[%0d] got=%0h exp=%0h", i, out_payload, first); else n_pass++;
        end
        n_checks++; if (overflow !== 2'b10) $display("FAIL bp_overflow got=%b exp=10", overflow); else n_pass++;
        n_checks++; if (h1_ready !== 1'b0) $display("FAIL bp_full_ready got=%0b exp=0", h1_ready); else n_pass++;
        exp_rec[0] = first; exp_id[0] = H0;
        for (int i = 1; i < 5; i++) begin exp_rec[i] = b[i-1]; exp_id[i] = H1; end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_hartid !== exp_id[i] || out_payload !== exp_rec[i]) $display("FAIL bp_drain[%0d] got=%0h/%0h exp=%0h/%0h", i, out_hartid, out_payload, exp_id[i], exp_rec[i]); else n_pass++;
            @(negedge clock);
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain_end got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (overflow !== 2'b10) $display("FAIL bp_overflow_sticky got=%b exp=10", overflow); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            h0_valid = 1'b1;     h0_payload = rand_rec();
            h1_valid = (i < 3);  h1_payload = rand_rec();
            @(negedge clock);
        end
        idle_inputs();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid got=%0b exp=1", out_valid); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_async_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_payload !== 144'd0 || out_hartid !== 8'd0 || out_tag !== 64'd0) $display("FAIL mid_async_data got=%0h/%0h/%0h exp=0", out_hartid, out_payload, out_tag); else n_pass++;
        n_checks++; if ({h1_ready, h0_ready} !== 2'b11) $display("FAIL mid_async_ready got=%b exp=11", {h1_ready, h0_ready}); else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_after_valid[%0d] got=%0b exp=0", i, out_valid); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 1;
        logic [143:0] sent [N];
        int idx;
        int got;
        do_reset();
        for (int i = 0; i < N; i++) sent[i] = make_rec(40'h50_0000_0000 + 40'(8 * i), 32'(300 + i));
        idx = 0;
        got = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 300 && got < N; c++) begin
            out_ready = ~out_ready;
            if (out_valid && out_ready) begin
                n_checks++; if (out_payload !== sent[got] || out_hartid !== H0) $display("FAIL wrap_rec[%0d] got=%0h exp=%0h", got, out_payload, sent[got]); else n_pass++;
                got++;
            end
            if (idx < N && q0.size() < DEPTH) begin
                h0_valid = 1'b1; h0_payload = sent[idx]; idx++;
            end else begin
                h0_valid = 1'b0;
            end
            @(negedge clock);
        end
        idle_inputs();
        n_checks++; if (got !== N) $display("FAIL wrap_count got=%0d exp=%0d", got, N); else n_pass++;
        n_checks++; if (overflow !== 2'b00) $display("FAIL wrap_overflow got=%b exp=00", overflow); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_checks++; if (out_valid !== m_out_valid) $display("FAIL rand_valid[%0d] got=%0b exp=%0b", c, out_valid, m_out_valid); else n_pass++;
            if (m_out_valid) begin
                n_checks++; if (out_hartid !== m_hartid) $display("FAIL rand_hartid[%0d] got=%0h exp=%0h", c, out_hartid, m_hartid); else n_pass++;
                n_checks++; if (out_payload !== m_payload) $display("FAIL rand_payload[%0d] got=%0h exp=%0h", c, out_payload, m_payload); else n_pass++;
                n_checks++; if (out_tag !== m_tag) $display("FAIL rand_tag[%0d] got=%0h exp=%0h", c, out_tag, m_tag); else n_pass++;
            end
            n_checks++; if (overflow !== m_ovf) $display("FAIL rand_overflow[%0d] got=%b exp=%b", c, overflow, m_ovf); else n_pass++;
            n_checks++; if (h0_ready !== (q0.size() < DEPTH)) $display("FAIL rand_h0_ready[%0d] got=%0b exp=%0b", c, h0_ready, (q0.size() < DEPTH)); else n_pass++;
            n_checks++; if (h1_ready !== (q1.size() < DEPTH)) $display("FAIL rand_h1_ready[%0d] got=%0b exp=%0b", c, h1_ready, (q1.size() < DEPTH)); else n_pass++;
            h0_valid   = ($urandom_range(0, 9) < 5);
            h1_valid   = ($urandom_range(0, 9) < 5);
            h0_payload = rand_rec();
            h1_payload = rand_rec();
            out_ready  = ($urandom_range(0, 9) < 6);
            @(negedge clock);
        end
        idle_inputs();
        out_ready = 1'b1;
        repeat (2 * DEPTH + 2) @(negedge clock);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rand_drain_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if ({h1_ready, h0_ready} !== 2'b11) $display("FAIL rand_drain_ready got=%b exp=11", {h1_ready, h0_ready}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_hart();
        test_tie();
        test_backpressure();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
